movegen_stack_ctrl: RTL

Controller for the move generator's piece stack: a chain of `DEPTH` single-entry registers, slot 0 at the head, each with a synchronous clear and a load enable. It does four things:
- sequences pushes from the generator and pops to the consumer;
- drives every slot's load enable, the shift direction and the common clear;
- tracks occupancy and a high-water mark;
- runs a clear sequence after reset and on each new-position flush.

The slots hold the data; this block holds no data.

---
 rtl/movegen_stack_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/movegen_stack_ctrl.sv
// Control sequencer for the move generator's piece stack: drives slot load/shift/clear,
// handles push/pop handshakes, and tracks occupancy and the high-water mark.
module movegen_stack_ctrl #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [DEPTH-1:0] stack_load,
    output logic             stack_shift_up,
    output logic             stack_clear,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    high_water
);

    typedef enum logic {
        CLR,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count_next;
    logic          push_hs;
    logic          pop_hs;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLR;
            count      <= '0;
            high_water <= '0;
        end else begin
            state <= state_next;
            if (state == CLR) begin
                count      <= '0;
                high_water <= '0;
            end else begin
                count <= count_next;
                if (count_next > high_water)
                    high_water <= count_next;
            end
        end
    end

    // Readiness never looks at pop_ready, so a replace-head can't happen while full.
    always_comb begin
        state_next     = state;
        push_ready     = 1'b0;
        pop_valid      = 1'b0;
        stack_load     = '0;
        stack_shift_up = 1'b0;
        stack_clear    = 1'b0;
        count_next     = count;
        push_hs        = 1'b0;
        pop_hs         = 1'b0;

        case (state)
            CLR: begin
                stack_clear = 1'b1;
                state_next  = RUN;
            end
            RUN: begin
                if (flush) begin
                    state_next = CLR;
                end else begin
                    push_ready = !full;
                    pop_valid  = !empty;
                    push_hs    = push_valid && push_ready;
                    pop_hs     = pop_valid && pop_ready;

                    if (push_hs && pop_hs) begin
                        stack_load[0] = 1'b1;
                    end else if (push_hs) begin
                        for (int i = 0; i < DEPTH; i++)
                            stack_load[i] = (CW'(i) <= count);
                        count_next = count + CW'(1);
                    end else if (pop_hs) begin
                        stack_shift_up = 1'b1;
                        for (int i = 0; i < DEPTH; i++)
                            stack_load[i] = (CW'(i) < count);
                        count_next = count - CW'(1);
                    end
                end
            end
            default: state_next = CLR;
        endcase
    end

    assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop_hs && empty));

endmodule
